// File: rtl/udp_meas_pkg.sv
// Shared types and helpers for the reference-clock period/duty meter.
// Holds the FSM state encoding, the count width, the saturation value
// and the packed measurement payload (period + high time).
package udp_meas_pkg;

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } meas_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
  } meas_result_t;

  // Increment that sticks at the saturation value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? CNT_SAT : v + CNT_W'(1);
  endfunction

  // Sum formed one bit wider so a carry out clamps to the saturation value.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? CNT_SAT : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/udp_edge_sync.sv
// Synchronizer and edge detector for an asynchronous single-bit input.
// Ports:
//   clk     - system clock (rising edge)
//   reset   - asynchronous, active-high; clears all flops
//   d_async - asynchronous input
//   rise    - one-cycle pulse, registered, SYNC_STAGES+1 cycles after a 0->1
//   fall    - one-cycle pulse, registered, SYNC_STAGES+1 cycles after a 1->0
module udp_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Metastability chain, previous-value flop and registered edge pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      prev_q <= sync_out;
      rise   <= sync_out & ~prev_q;
      fall   <= ~sync_out & prev_q;
    end
  end

endmodule

// File: rtl/udp_clk_meas.sv
// Measures the period and high time of an asynchronous reference/PWM clock
// in clk cycles. A full measurement needs rise -> fall -> rise; the first rise
// after reset, disable or a timeout only arms the meter.
// Ports:
//   clk        - system clock (rising edge)
//   reset      - asynchronous, active-high
//   enable     - measurement enable; low forces IDLE and clears the counters
//   ref_in     - asynchronous reference clock being measured
//   period     - last measured period (clk cycles)
//   high_time  - last measured high duration (clk cycles)
//   meas_valid - one-cycle pulse when period/high_time update
//   locked     - high after a valid measurement, low on timeout/disable
//   lost       - sticky timeout flag, cleared by the next valid measurement
module udp_clk_meas
  import udp_meas_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 32'd1_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ref_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             lost
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic rise;
  logic fall;

  meas_state_e      state_q,      state_d;
  logic [CNT_W-1:0] hi_cnt_q,     hi_cnt_d;
  logic [CNT_W-1:0] lo_cnt_q,     lo_cnt_d;
  meas_result_t     result_q,     result_d;
  logic             meas_valid_q, meas_valid_d;
  logic             locked_q,     locked_d;
  logic             lost_q,       lost_d;

  udp_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk    (clk),
    .reset  (reset),
    .d_async(ref_in),
    .rise   (rise),
    .fall   (fall)
  );

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hi_cnt_q     <= '0;
      lo_cnt_q     <= '0;
      result_q     <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_cnt_q     <= hi_cnt_d;
      lo_cnt_q     <= lo_cnt_d;
      result_q     <= result_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      lost_q       <= lost_d;
    end
  end

  // Next-state and next-output logic; an edge always beats a timeout.
  always_comb begin
    state_d      = state_q;
    hi_cnt_d     = hi_cnt_q;
    lo_cnt_d     = lo_cnt_q;
    result_d     = result_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    lost_d       = lost_q;

    if (!enable) begin
      state_d  = IDLE;
      hi_cnt_d = '0;
      lo_cnt_d = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d  = HIGH;
            hi_cnt_d = CNT_W'(1);
            lo_cnt_d = '0;
          end
        end
        HIGH: begin
          if (fall) begin
            state_d  = LOW;
            lo_cnt_d = CNT_W'(1);
          end else if (hi_cnt_q == TIMEOUT_CNT) begin
            state_d  = IDLE;
            hi_cnt_d = '0;
            lo_cnt_d = '0;
            lost_d   = 1'b1;
            locked_d = 1'b0;
          end else begin
            hi_cnt_d = sat_inc(hi_cnt_q);
          end
        end
        LOW: begin
          if (rise) begin
            state_d            = HIGH;
            result_d.period    = sat_add(hi_cnt_q, lo_cnt_q);
            result_d.high_time = hi_cnt_q;
            meas_valid_d       = 1'b1;
            locked_d           = 1'b1;
            lost_d             = 1'b0;
            hi_cnt_d           = CNT_W'(1);
            lo_cnt_d           = '0;
          end else if (lo_cnt_q == TIMEOUT_CNT) begin
            state_d  = IDLE;
            hi_cnt_d = '0;
            lo_cnt_d = '0;
            lost_d   = 1'b1;
            locked_d = 1'b0;
          end else begin
            lo_cnt_d = sat_inc(lo_cnt_q);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign period     = result_q.period;
  assign high_time  = result_q.high_time;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign lost       = lost_q;

endmodule

// File: tb/tb_udp_clk_meas.sv
// Testbench for udp_clk_meas: table of steady waveforms plus directed
// corner sequences and a randomized jitter run, all checked every cycle
// against a level/event model of the input waveform.
module tb_udp_clk_meas;

  localparam int TO = 100;
  localparam int N  = 2;
  localparam int LAT = N + 2;  // input change -> registered output

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        ref_in;
  logic [31:0] period;
  logic [31:0] high_time;
  logic        meas_valid;
  logic        locked;
  logic        lost;

  udp_clk_meas #(
    .TIMEOUT    (32'd100),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .ref_in    (ref_in),
    .period    (period),
    .high_time (high_time),
    .meas_valid(meas_valid),
    .locked    (locked),
    .lost      (lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Expected output events derived from the input waveform.
  typedef struct {
    int          t;
    int          kind;   // 0 measurement, 1 timeout, 2 disable
    logic [31:0] per;
    logic [31:0] hi;
  } ev_t;
  ev_t evq[$];

  typedef struct {
    int          hi_len;
    int          lo_len;
    int          reps;
    logic [31:0] exp_period;
    logic [31:0] exp_high;
  } vec_t;
  vec_t tbl[$];

  // Waveform-level model state.
  logic m_lvl;
  bit   m_en, m_armed, m_have_fall;
  int   m_rise_t, m_fall_t, m_lvl_start;

  logic        exp_mv, exp_locked, exp_lost, prev_mv;
  logic [31:0] exp_period, exp_high, last_p, last_h;
  int          mv_cnt;
  bit          jit_phase;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  task automatic model_reset();
    evq.delete();
    m_lvl = 1'b0; m_armed = 0; m_have_fall = 0;
    exp_mv = 0; exp_locked = 0; exp_lost = 0; exp_period = '0; exp_high = '0;
  endtask

  // Apply the measurement rules to an input transition at the current cycle.
  task automatic model_edge(input logic v);
    ev_t e;
    if (v == m_lvl) return;
    m_lvl = v;
    if (!m_en) return;
    if (v) begin
      if (m_armed && m_have_fall) begin
        e = '{cyc + LAT, 0, 32'(cyc - m_rise_t), 32'(m_fall_t - m_rise_t)};
        evq.push_back(e);
      end
      m_armed = 1; m_have_fall = 0; m_rise_t = cyc; m_lvl_start = cyc;
    end else if (m_armed) begin
      m_have_fall = 1; m_fall_t = cyc; m_lvl_start = cyc;
    end
  endtask

  task automatic model_disable();
    ev_t e;
    e = '{cyc + 1, 2, 32'd0, 32'd0};
    evq.push_back(e);
    m_armed = 0; m_en = 0;
  endtask

  // One clock: compare all outputs, then age the model by a cycle.
  task automatic step();
    ev_t e;
    @(negedge clk);
    exp_mv = 1'b0;
    while (evq.size() > 0 && evq[0].t <= cyc) begin
      e = evq.pop_front();
      chk("event_time", 32'(cyc), 32'(e.t));
      case (e.kind)
        0: begin exp_mv = 1; exp_period = e.per; exp_high = e.hi; exp_locked = 1; exp_lost = 0; end
        1: begin exp_lost = 1; exp_locked = 0; end
        default: exp_locked = 0;
      endcase
    end
    chk("meas_valid", 32'(meas_valid), 32'(exp_mv));
    chk("locked", 32'(locked), 32'(exp_locked));
    chk("lost", 32'(lost), 32'(exp_lost));
    chk("period", period, exp_period);
    chk("high_time", high_time, exp_high);
    if (meas_valid) begin
      chk("mv_double", 32'(prev_mv), 32'd0);
      mv_cnt++;
      last_p = period;
      last_h = high_time;
      if (jit_phase) begin
        checks++;
        if (period < 32'd49 || period > 32'd51) begin
          errors++;
          $display("FAIL jitter_period at cycle %0d: got %0d expected 49..51", cyc, period);
        end
      end
    end
    prev_mv = meas_valid;
    // A level still unchanged TO+1 cycles after it began exceeds the limit.
    if (m_armed && m_en && cyc == m_lvl_start + TO + 1) begin
      e = '{m_lvl_start + TO + LAT, 1, 32'd0, 32'd0};
      evq.push_back(e);
      m_armed = 0;
    end
  endtask

  task automatic drive(input logic v, input int n);
    ref_in = v;
    model_edge(v);
    repeat (n) step();
  endtask

  initial begin
    vec_t v;
    int   n0;
    int   jit[41];

    reset = 1'b1; enable = 1'b1; ref_in = 1'b0;
    m_en = 1; prev_mv = 0; mv_cnt = 0; jit_phase = 0; last_p = '0; last_h = '0;
    model_reset();
    repeat (3) step();
    chk("rst_period", period, 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    reset = 1'b0;
    model_edge(ref_in);

    // Steady waveforms: {high, low, periods, expected period, expected high}.
    v = '{5, 5, 20, 32'd10, 32'd5};      tbl.push_back(v);
    v = '{2, 2, 4, 32'd4, 32'd2};        tbl.push_back(v);
    v = '{7, 13, 4, 32'd20, 32'd7};      tbl.push_back(v);
    for (int h = 1; h < 20; h++) begin
      v = '{h, 20 - h, 3, 32'd20, 32'(h)};
      tbl.push_back(v);
    end
    v = '{TO, TO, 3, 32'd200, 32'd100};  tbl.push_back(v);

    for (int i = 0; i < tbl.size(); i++) begin
      repeat (tbl[i].reps) begin
        drive(1'b1, tbl[i].hi_len);
        drive(1'b0, tbl[i].lo_len);
      end
      chk("tbl_period", last_p, tbl[i].exp_period);
      chk("tbl_high", last_h, tbl[i].exp_high);
      chk("tbl_locked", 32'(locked), 32'd1);
    end

    // High held past the limit: lost, unlocked, no pulse; two rises recover.
    drive(1'b1, 10);
    n0 = mv_cnt;
    drive(1'b1, 140);
    chk("to_no_valid", 32'(mv_cnt - n0), 32'd0);
    chk("to_lost", 32'(lost), 32'd1);
    chk("to_locked", 32'(locked), 32'd0);
    drive(1'b0, 10); drive(1'b1, 10); drive(1'b0, 10); drive(1'b1, 10);
    chk("rec_locked", 32'(locked), 32'd1);
    chk("rec_lost", 32'(lost), 32'd0);

    // Low for exactly TO: the rise still wins.
    drive(1'b0, TO);
    drive(1'b1, 10);
    chk("edge_win_period", period, 32'd110);
    chk("edge_win_lost", 32'(lost), 32'd0);
    // Low for TO+1: timeout in LOW.
    drive(1'b0, TO + 1);
    drive(1'b1, 10);
    chk("lo_to_lost", 32'(lost), 32'd1);
    drive(1'b0, 10); drive(1'b1, 10);
    chk("lo_rec_locked", 32'(locked), 32'd1);

    // Reset asserted mid-HIGH, while a measurement is still in the pipeline.
    drive(1'b0, 10);
    drive(1'b1, 3);
    reset = 1'b1;
    model_reset();
    repeat (3) step();
    chk("mid_rst_high", high_time, 32'd0);
    reset = 1'b0;
    model_edge(ref_in);
    n0 = mv_cnt;
    drive(1'b1, 5); drive(1'b0, 5);
    chk("rst_first_rise", 32'(mv_cnt - n0), 32'd0);
    drive(1'b1, 5); drive(1'b0, 10);
    chk("rst_meas_period", period, 32'd10);

    // Disable mid-LOW: outputs hold, locked drops, re-arm needs two rises.
    enable = 1'b0;
    model_disable();
    repeat (10) step();
    chk("dis_locked", 32'(locked), 32'd0);
    chk("dis_period", period, 32'd10);
    chk("dis_high", high_time, 32'd5);
    enable = 1'b1;
    m_en = 1;
    repeat (5) step();
    n0 = mv_cnt;
    drive(1'b1, 5); drive(1'b0, 5);
    chk("en_first_rise", 32'(mv_cnt - n0), 32'd0);
    drive(1'b1, 5); drive(1'b0, 5);
    chk("en_locked", 32'(locked), 32'd1);

    // Rise edges jittered by one clock around a fixed 50-cycle grid.
    for (int k = 0; k < 41; k++) jit[k] = int'($urandom_range(1, 0));
    for (int k = 0; k < 40; k++) begin
      if (k == 1) jit_phase = 1;
      drive(1'b1, 25 - jit[k]);
      drive(1'b0, 25 + jit[k + 1]);
    end
    jit_phase = 0;
    chk("jit_locked", 32'(locked), 32'd1);

    repeat (LAT + 4) step();
    chk("events_drained", 32'(evq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_clk_meas.md
UDP_CLK_MEAS -- requirements
Module: udp_clk_meas

Interface
REQ-001 Parameter TIMEOUT, default 32'd1_000_000, is the maximum number of clk cycles allowed in one input level before the link is declared lost.
REQ-002 Parameter SYNC_STAGES, default 2, is the synchronizer depth for ref_in; legal values are 2 to 4.
REQ-003 The reset input is asynchronous and active-high; the clock is clk.
REQ-004 Port list:
 clk  input  1  system clock; all logic on rising edge
 reset  input  1  asynchronous, active-high
 enable  input  1  measurement enable; low forces IDLE
 ref_in  input  1  asynchronous reference/PWM clock to be measured
 period  output  32  last measured period, in clk cycles
 high_time  output  32  last measured high duration, in clk cycles
 meas_valid  output  1  one-cycle pulse when period/high_time update
 locked  output  1  high after the first valid measurement, low on timeout/disable
 lost  output  1  sticky timeout flag, cleared by the next valid measurement

Function
REQ-005 ref_in SHALL pass through SYNC_STAGES flops, then one edge-detect flop; rise/fall pulses SHALL occur SYNC_STAGES+1 cycles after the input transition.
REQ-006 The FSM SHALL have states IDLE, HIGH and LOW.
REQ-007 IDLE: on rise -> HIGH, hi_cnt=1, lo_cnt=0, no output update; a fall in IDLE SHALL be ignored.
REQ-008 HIGH: each cycle without an edge, hi_cnt+1; on fall -> LOW, lo_cnt=1.
REQ-009 LOW: each cycle without an edge, lo_cnt+1; on rise -> HIGH, period=hi_cnt+lo_cnt, high_time=hi_cnt, meas_valid=1 for one cycle, locked=1, lost=0, hi_cnt=1, lo_cnt=0.
REQ-010 A rise in HIGH or a fall in LOW is impossible after edge detection and SHALL be ignored.
REQ-011 Counters SHALL saturate at 32'hFFFF_FFFF; the period sum SHALL be computed at 33 bits and saturate to 32'hFFFF_FFFF.
REQ-012 Timeout: if no edge occurs and hi_cnt (in HIGH) or lo_cnt (in LOW) equals TIMEOUT, the FSM SHALL go to IDLE, set lost=1 and locked=0, and SHALL NOT pulse meas_valid; period and high_time SHALL hold.
REQ-013 An edge and a timeout condition in the same cycle: the edge SHALL win.
REQ-014 enable low SHALL force IDLE within one cycle, clear locked, clear the counters and hold period, high_time and lost; raising enable re-arms from IDLE.
REQ-015 For a steady input with period P and high time H (both >= 2, and less than TIMEOUT per level), every measurement after the first SHALL report period=P and high_time=H exactly.
REQ-016 meas_valid SHALL never be high for two consecutive cycles.

Reset
REQ-017 Reset SHALL clear all synchronizer and edge flops to 0, put the FSM in IDLE, zero both counters, and drive period=0, high_time=0, meas_valid=0, locked=0, lost=0.
REQ-018 Reset asserted mid-measurement SHALL discard the partial counts; the first rise after release only arms the block.

Structure
REQ-019 Package udp_meas_pkg SHALL hold the state enum (IDLE/HIGH/LOW), the 32-bit count width constant and the saturation value.
REQ-020 Synchronizer plus edge detect SHALL be sub-module udp_edge_sync (ports: clk, reset, d_async, rise, fall); the FSM, counters and output registers stay in udp_clk_meas.

Verification
REQ-021 ref_in period 10, high 5, 20 periods -> first meas_valid on the second rise; every pulse reports period=10, high_time=5; locked=1.
REQ-022 Duty sweep at period 20 with high 1..19 (hold >= 3 cycles per setting) -> after settling, high_time tracks exactly and period=20.
REQ-023 TIMEOUT=100, ref_in held high for 150 cycles after lock -> lost=1 and locked=0 at hi_cnt=100; no meas_valid; the following two rises restore locked and clear lost.
REQ-024 Rise arriving on the exact cycle lo_cnt=TIMEOUT -> measurement reported, no timeout.
REQ-025 Assert reset mid-HIGH, then enable low mid-LOW -> outputs match REQ-017 and REQ-014; the first subsequent rise produces no meas_valid.
REQ-026 Random async ref_in jitter of +/-1 clk against a fixed 50-cycle period -> period within 49..51, with no double meas_valid.
